// File: rtl/ps2kb_scan_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard scan-code controller:
// decoder states, prefix bytes and event field layout.
package ps2kb_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGotE0,
    StGotF0,
    StGotE0F0
  } state_e;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam int unsigned EV_W        = 10;
  localparam int unsigned EV_EXT      = 9;
  localparam int unsigned EV_BRK      = 8;
  localparam int unsigned EV_CODE_MSB = 7;
  localparam int unsigned EV_CODE_LSB = 0;

  function automatic logic [EV_W-1:0] make_ev(input logic ext, input logic brk,
                                              input logic [7:0] code);
    logic [EV_W-1:0] ev;
    ev                           = '0;
    ev[EV_EXT]                   = ext;
    ev[EV_BRK]                   = brk;
    ev[EV_CODE_MSB:EV_CODE_LSB]  = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign valid   = (count_q != '0);
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage is not reset; its contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2kb_scan_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext, brk, code} events,
// abandons stale prefixes after a timeout, and queues events in a FIFO.
module ps2kb_scan_ctrl
  import ps2kb_scan_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        rx_done_tick,
  input  logic [7:0]                  rx_data,
  output logic                        rx_en,
  output logic                        ev_valid,
  output logic [EV_W-1:0]             ev_data,
  input  logic                        ev_rd,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            push;
  logic [EV_W-1:0] push_ev;
  logic            drop;
  logic            rx_en_q, ovf_q;
  logic            is_pfx;

  assign is_pfx = (rx_data == PFX_EXT) || (rx_data == PFX_BRK);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    push    = 1'b0;
    push_ev = make_ev(1'b0, 1'b0, rx_data);
    if (rx_done_tick) begin
      tmo_d = '0;
      case (state_q)
        StIdle: begin
          if (rx_data == PFX_EXT)      state_d = StGotE0;
          else if (rx_data == PFX_BRK) state_d = StGotF0;
          else                         push    = 1'b1;
        end
        StGotE0: begin
          if (rx_data == PFX_BRK) begin
            state_d = StGotE0F0;
          end else if (rx_data != PFX_EXT) begin
            push    = 1'b1;
            push_ev = make_ev(1'b1, 1'b0, rx_data);
            state_d = StIdle;
          end
        end
        StGotF0: begin
          push    = ~is_pfx;
          push_ev = make_ev(1'b0, 1'b1, rx_data);
          state_d = StIdle;
        end
        StGotE0F0: begin
          push    = ~is_pfx;
          push_ev = make_ev(1'b1, 1'b1, rx_data);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // A prefix whose follow-on byte never arrives is abandoned silently.
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = StIdle;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ev),
    .pop       (ev_rd),
    .valid     (ev_valid),
    .rd_data   (ev_data),
    .count     (ev_count),
    .drop      (drop)
  );

  // One slot stays free for a frame the receiver may already be shifting in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_en_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rx_en_q <= en & (ev_count < ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH - 1));
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign rx_en    = rx_en_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2kb_scan_ctrl.sv
// Scoreboard bench: a prefix-folding reference model feeds an expected-event
// queue; a negedge monitor compares DUT outputs against it.
module tb_ps2kb_scan_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 50;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    rx_done_tick = 1'b0;
  logic [7:0]              rx_data = 8'h00;
  logic                    ev_rd = 1'b0;
  logic                    ovf_clr = 1'b0;
  logic                    rx_en, ev_valid, overflow;
  logic [9:0]              ev_data;
  logic [$clog2(DEPTH):0]  ev_count;

  always #5 clk = ~clk;

  ps2kb_scan_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .ev_valid     (ev_valid),
    .ev_data      (ev_data),
    .ev_rd        (ev_rd),
    .ev_count     (ev_count),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] exp_q[$];
  bit         exp_ovf   = 1'b0;
  bit         exp_rx_en = 1'b0;
  int         rd_mode   = 0;  // 0: never pop, 1: random, 2: always

  bit         ext_pend = 1'b0;
  bit         brk_pend = 1'b0;
  longint     edge_n = 0;
  longint     last_tick = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: prefix flags plus gap since the last byte.
  initial begin
    bit         nxt_rx_en, do_pop, full, emit, ovf_evt;
    logic [9:0] ev;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_rx_en = 1'b0;
        ext_pend  = 1'b0;
        brk_pend  = 1'b0;
        continue;
      end
      nxt_rx_en = en && (exp_q.size() < int'(DEPTH) - 1);
      do_pop    = ev_rd && (exp_q.size() > 0);
      full      = (exp_q.size() == int'(DEPTH));
      emit      = 1'b0;
      ovf_evt   = 1'b0;
      ev        = '0;
      if (rx_done_tick) begin
        if ((ext_pend || brk_pend) && (edge_n - last_tick > longint'(TMO))) begin
          ext_pend = 1'b0;
          brk_pend = 1'b0;
        end
        last_tick = edge_n;
        if (rx_data == 8'hE0 || rx_data == 8'hF0) begin
          if (brk_pend) begin
            ext_pend = 1'b0;
            brk_pend = 1'b0;
          end else if (rx_data == 8'hE0) begin
            ext_pend = 1'b1;
          end else begin
            brk_pend = 1'b1;
          end
        end else begin
          emit     = 1'b1;
          ev       = {ext_pend, brk_pend, rx_data};
          ext_pend = 1'b0;
          brk_pend = 1'b0;
        end
        if (emit && full && !do_pop) ovf_evt = 1'b1;
      end
      if (do_pop) void'(exp_q.pop_front());
      if (emit && !ovf_evt) exp_q.push_back(ev);
      if (ovf_evt)      exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
      exp_rx_en = nxt_rx_en;
    end
  end

  // Monitor: compares status every cycle and the head whenever it is consumed.
  initial begin
    bit r;
    forever begin
      @(negedge clk);
      check("ev_valid", longint'(ev_valid), longint'(exp_q.size() != 0));
      check("ev_count", longint'(ev_count), longint'(exp_q.size()));
      check("overflow", longint'(overflow), longint'(exp_ovf));
      check("rx_en", longint'(rx_en), longint'(exp_rx_en));
      case (rd_mode)
        0:       r = 1'b0;
        1:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      ev_rd = r;
      if (r && ev_valid && exp_q.size() != 0) begin
        check("ev_data", longint'(ev_data), longint'(exp_q[0]));
      end
    end
  end

  // Called at a negedge; the byte is sampled at the following posedge.
  task automatic send(input logic [7:0] b, input int idle, input bit clr = 1'b0);
    rx_done_tick = 1'b1;
    rx_data      = b;
    ovf_clr      = clr;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_data      = 8'($urandom);
    ovf_clr      = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    int unsigned pick;
    logic [7:0]  b;
    int          idle;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    en      = 1'b1;
    rd_mode = 2;

    send(8'h1C, 3);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 3);
    send(8'hE0, TMO);     send(8'h1C, 3);
    send(8'hE0, TMO - 1); send(8'h1C, 3);
    send(8'hF0, 2);       send(8'hE0, 0); send(8'h33, 3);

    // Fill past capacity, then push and pop together while full.
    #1 rd_mode = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) send(8'h15 + 8'(i), 1);
    repeat (2) @(negedge clk);
    #1 rd_mode = 2;
    @(negedge clk);
    send(8'h2A, 0);
    #1 rd_mode = 0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    send(8'h00, 1, 1'b1);
    #1 rd_mode = 2;
    @(negedge clk);
    repeat (6) @(negedge clk);

    // Reset while a break prefix is pending and events are queued.
    #1 rd_mode = 0;
    @(negedge clk);
    send(8'h41, 0); send(8'hF0, 2);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    send(8'h1C, 3);
    #1 rd_mode = 1;
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 25)      b = 8'hE0;
      else if (pick < 50) b = 8'hF0;
      else                b = 8'($urandom);
      pick = $urandom_range(0, 99);
      if (pick < 8) idle = int'($urandom_range(TMO - 2, TMO + 1));
      else          idle = int'($urandom_range(0, 4));
      if (i % 25 == 0) rd_mode = int'($urandom_range(0, 2));
      en = ($urandom_range(0, 9) != 0);
      send(b, idle, ($urandom_range(0, 9) == 0));
    end

    #1 rd_mode = 2;
    @(negedge clk);
    repeat (DEPTH + 4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/ps2kb_scan_ctrl.md
PS2KB_SCAN_CTRL -- requirements
Module: ps2kb_scan_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
REQ-002 Parameter TIMEOUT_CYC, 200000, maximum clk cycles allowed between a prefix byte and its follow-on byte.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  host enable for scan reception.
REQ-006 rx_done_tick  input  1  one-cycle strobe from the PS/2 receiver marking a valid byte.
REQ-007 rx_data  input  8  received byte; valid only while rx_done_tick=1.
REQ-008 rx_en  output  1  receive-start enable to the PS/2 receiver.
REQ-009 ev_valid  output  1  FIFO non-empty; ev_data holds the head event.
REQ-010 ev_data  output  10  head event {ext, brk, code[7:0]}.
REQ-011 ev_rd  input  1  pop head event; ignored while ev_valid=0.
REQ-012 ev_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-014 ovf_clr  input  1  clears overflow.

Function
REQ-015 The FSM SHALL have states IDLE, GOT_E0, GOT_F0 and GOT_E0F0, and SHALL act only on cycles with rx_done_tick=1, apart from the timeout.
REQ-016 IDLE SHALL go to GOT_E0 on 0xE0, go to GOT_F0 on 0xF0, and otherwise push {0,0,byte}.
REQ-017 GOT_E0 SHALL go to GOT_E0F0 on 0xF0, stay in GOT_E0 on 0xE0, and otherwise push {1,0,byte} and go to IDLE.
REQ-018 GOT_F0 SHALL push {0,1,byte} and go to IDLE; a byte of 0xE0 or 0xF0 SHALL be discarded without a push, returning to IDLE.
REQ-019 GOT_E0F0 SHALL push {1,1,byte} and go to IDLE; a byte of 0xE0 or 0xF0 SHALL be discarded without a push, returning to IDLE.
REQ-020 A timeout counter SHALL clear on entry to IDLE and on every rx_done_tick, and SHALL count up in the non-IDLE states.
REQ-021 When the timeout counter reaches TIMEOUT_CYC-1, the FSM SHALL return to IDLE with no push; an rx_done_tick in the same cycle SHALL take priority over the timeout.
REQ-022 The event FIFO SHALL be first-word-fall-through: a push written at the rx_done_tick edge SHALL be visible on ev_valid/ev_data on the following cycle (1-cycle latency).
REQ-023 A pop SHALL occur when ev_rd=1 and ev_valid=1, and SHALL advance the head at the clock edge.
REQ-024 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full, with ev_count unchanged.
REQ-025 A push while the FIFO is full and no pop is occurring SHALL drop the event, leave the FIFO unchanged and set overflow=1.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 ovf_clr SHALL clear overflow on the next edge; a simultaneous overflow event SHALL win, leaving overflow=1.
REQ-028 rx_en SHALL be registered and SHALL equal en & (ev_count < FIFO_DEPTH-1), so that one slot is reserved for a frame already in flight.
REQ-029 When en=0, the FSM SHALL still process an rx_done_tick already in flight; the FSM SHALL NOT be reset by en.

Reset
REQ-030 Reset SHALL set: FSM IDLE; timeout counter 0; FIFO pointers 0; ev_count 0; ev_valid 0; overflow 0; rx_en 0.
REQ-031 ev_data SHALL be don't-care while ev_valid=0; the bench SHALL NOT check it.
REQ-032 Reset asserted mid-sequence, for example in GOT_E0F0, SHALL discard the partial prefix and all FIFO contents.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the constants PFX_EXT=8'hE0 and PFX_BRK=8'hF0, and the event field positions (EXT=9, BRK=8, CODE=7:0).
REQ-034 The FIFO SHALL be a separate sub-module, ps2_evt_fifo, parameterised by depth and width, with the FSM and timeout logic in the top module.

Verification
REQ-035 Bytes 0x1C -> one event of 0x01C, with ev_valid asserted 1 cycle after the tick.
REQ-036 Bytes E0,F0,75 -> exactly one event of 0x375; no events emitted for the prefixes.
REQ-037 Byte E0, then no byte for TIMEOUT_CYC cycles, then 0x1C -> FSM back in IDLE after the timeout; single event 0x01C.
REQ-038 FIFO_DEPTH=4 with 5 bytes and no pops -> ev_count=4, overflow=1, the first 4 events intact, and rx_en=0 from the cycle after ev_count reaches 3.
REQ-039 FIFO full with simultaneous ev_rd and push -> ev_count stays 4, the head advances, and the new event is stored at the tail.
REQ-040 Reset asserted after F0 has been received, then 0x1C sent -> event 0x01C (brk=0), overflow=0.
